// File: rtl/wb_scoreboard_pkg.sv
// Shared definitions for the writeback scoreboard: default sizing and drain FSM encoding.
package wb_scoreboard_pkg;

    localparam int SB_NREGS = 32;
    localparam int SB_CNT_W = 2;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_DRAIN = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_e;

    // Plain-vector aliases so state registers stay simple logic vectors
    localparam logic [1:0] ST_RUN   = SB_RUN;
    localparam logic [1:0] ST_DRAIN = SB_DRAIN;
    localparam logic [1:0] ST_DONE  = SB_DONE;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Issue/writeback/control bundle between the pipeline (master) and the scoreboard (slave).
interface wb_scoreboard_if
    import wb_scoreboard_pkg::*;
#(
    parameter int NREGS = SB_NREGS
);

    logic             issue_valid;
    logic             issue_reg_write;
    logic [4:0]       issue_rd;
    logic [4:0]       issue_rs;
    logic [4:0]       issue_rt;
    logic             issue_uses_rs;
    logic             issue_uses_rt;
    logic             reg_write_wb;
    logic [4:0]       rd_wb;
    logic             flush;
    logic             drain_req;
    logic             stall_id;
    logic             drain_done;
    logic [NREGS-1:0] busy_mask;
    logic [15:0]      stall_cnt;
    logic             underflow_err;

    modport master (
        output issue_valid, issue_reg_write, issue_rd, issue_rs, issue_rt,
               issue_uses_rs, issue_uses_rt, reg_write_wb, rd_wb, flush, drain_req,
        input  stall_id, drain_done, busy_mask, stall_cnt, underflow_err
    );

    modport slave (
        input  issue_valid, issue_reg_write, issue_rd, issue_rs, issue_rt,
               issue_uses_rs, issue_uses_rt, reg_write_wb, rd_wb, flush, drain_req,
        output stall_id, drain_done, busy_mask, stall_cnt, underflow_err
    );

endinterface

// File: rtl/wb_scoreboard_sb_counter.sv
// One pending-write counter: saturating up/down, synchronous clear has priority.
module sb_counter
    import wb_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Simultaneous inc and dec cancel out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec && count != CNT_MAX) begin
            count <= count + CNT_ONE;
        end else if (dec && !inc && count != '0) begin
            count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-file scoreboard: tracks pending writes per register, stalls ID on hazards,
// and supports pipeline flush and a drain handshake.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic clk,
    input  logic reset,
    wb_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] inc;
    logic [NREGS-1:0] dec;
    logic [NREGS-1:0] hit_wb;
    logic [NREGS-1:0] eff_busy;
    logic [NREGS-1:0] nxt_zero;
    logic [NREGS-1:0] busy_q;
    logic [15:0]      stall_cnt_q;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             underflow_q;
    logic             stall;
    logic             accept;
    logic             busy_rs;
    logic             busy_rt;
    logic             rd_full;
    logic             all_zero_nxt;

    // Writeback updates the file at negedge, so a register whose only pending write
    // retires this cycle is already readable by ID.
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        assign hit_wb[i]   = sb.reg_write_wb && (sb.rd_wb == 5'(i));
        assign eff_busy[i] = (cnt[i] != '0) && !(hit_wb[i] && cnt[i] == CNT_ONE);
        if (i == 0) begin : g_zero
            assign cnt[i] = '0;
            assign inc[i] = 1'b0;
            assign dec[i] = 1'b0;
        end else begin : g_cnt
            assign inc[i] = accept && (sb.issue_rd == 5'(i));
            assign dec[i] = hit_wb[i] && (cnt[i] != '0);
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc[i]),
                .dec   (dec[i]),
                .clr   (sb.flush),
                .count (cnt[i])
            );
        end
        assign nxt_zero[i] = sb.flush ||
                             (!inc[i] && (cnt[i] == '0 || (cnt[i] == CNT_ONE && dec[i])));
    end

    assign busy_rs      = sb.issue_uses_rs && eff_busy[sb.issue_rs];
    assign busy_rt      = sb.issue_uses_rt && eff_busy[sb.issue_rt];
    assign rd_full      = sb.issue_reg_write && (cnt[sb.issue_rd] == CNT_MAX) &&
                          !hit_wb[sb.issue_rd];
    assign stall        = sb.issue_valid &&
                          (busy_rs || busy_rt || rd_full || state != ST_RUN);
    assign accept       = sb.issue_valid && !stall && sb.issue_reg_write &&
                          (sb.issue_rd != 5'd0);
    assign all_zero_nxt = &nxt_zero;

    // Drain completes when the counters will be empty after this cycle's update
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (sb.drain_req) state_nxt = ST_DRAIN;
            ST_DRAIN: if (sb.flush || all_zero_nxt) state_nxt = ST_DONE;
            ST_DONE:  if (!sb.drain_req) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            busy_q      <= '0;
            stall_cnt_q <= '0;
            underflow_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= ~nxt_zero;
            if (sb.issue_valid && stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (sb.reg_write_wb && sb.rd_wb != 5'd0 && cnt[sb.rd_wb] == '0) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign sb.stall_id      = stall;
    assign sb.drain_done    = (state == ST_DONE);
    assign sb.busy_mask     = busy_q;
    assign sb.stall_cnt     = stall_cnt_q;
    assign sb.underflow_err = underflow_q;

endmodule
